// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60 raster), total-length helper and DAC-side types.
// Consumed by vga_timing_gen and vga_axis_counter.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Non-colour DAC signals travel together so every pipeline stage stays aligned.
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
        logic frame_start;
    } dac_ctl_t;

    localparam dac_ctl_t DAC_CTL_RST = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on en_i and wraps, with carry_o flagging the wrap cycle.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         carry_o
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == LAST);
    assign carry_o = en_i && at_last;
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: coordinate out to the drawing controller, registered colour/sync/blank to the DAC.
// Define VGA_EXTRA_PIPE_EN to add one more output register stage (DAC latency 2 pixEn cycles instead of 1).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixEn,
    output logic [9:0] xPixel,
    output logic [8:0] yPixel,
    input  logic [7:0] inR,
    input  logic [7:0] inG,
    input  logic [7:0] inB,
    output logic [7:0] VGAr,
    output logic [7:0] VGAg,
    output logic [7:0] VGAb,
    output logic       VGAhs,
    output logic       VGAvs,
    output logic       VGAblankN,
    output logic       frameStart
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_ACT_C = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_BEG  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_ACT_C = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_BEG  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [H_W-1:0] h_cnt;
    logic [V_W-1:0] v_cnt;
    logic           h_carry;
    logic           v_carry;
    logic           sof_q;
    logic           active;
    logic [9:0]     x_d, x_q;
    logic [8:0]     y_d, y_q;
    dac_ctl_t       s1_d, s1_q;
    rgb_t           rgb2_d, rgb2_q;
    dac_ctl_t       ctl2_q;
    rgb_t           rgb_out;
    dac_ctl_t       ctl_out;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(H_W)) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (pixEn),
        .cnt_o   (h_cnt),
        .carry_o (h_carry)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .W(V_W)) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (h_carry),
        .cnt_o   (v_cnt),
        .carry_o (v_carry)
    );

    always_comb begin
        active         = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        x_d            = active ? 10'(h_cnt) : '0;
        y_d            = active ? 9'(v_cnt) : '0;
        s1_d.hs_n      = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        s1_d.vs_n      = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        s1_d.blank_n   = active;
        s1_d.frame_start = sof_q;
    end

    // sof_q marks that the counters sit on pixel (0,0); the vertical wrap re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_q <= 1'b1;
            x_q   <= '0;
            y_q   <= '0;
            s1_q  <= DAC_CTL_RST;
        end else if (pixEn) begin
            sof_q <= v_carry;
            x_q   <= x_d;
            y_q   <= y_d;
            s1_q  <= s1_d;
        end
    end

    always_comb begin
        rgb2_d = '0;
        if (s1_q.blank_n) begin
            rgb2_d = '{r: inR, g: inG, b: inB};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb2_q <= '0;
            ctl2_q <= DAC_CTL_RST;
        end else if (pixEn) begin
            rgb2_q <= rgb2_d;
            ctl2_q <= s1_q;
        end
    end

`ifdef VGA_EXTRA_PIPE_EN
    rgb_t     rgb3_q;
    dac_ctl_t ctl3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb3_q <= '0;
            ctl3_q <= DAC_CTL_RST;
        end else if (pixEn) begin
            rgb3_q <= rgb2_q;
            ctl3_q <= ctl2_q;
        end
    end

    assign rgb_out = rgb3_q;
    assign ctl_out = ctl3_q;
`else
    assign rgb_out = rgb2_q;
    assign ctl_out = ctl2_q;
`endif

    assign xPixel     = x_q;
    assign yPixel     = y_q;
    assign VGAr       = rgb_out.r;
    assign VGAg       = rgb_out.g;
    assign VGAb       = rgb_out.b;
    assign VGAhs      = ctl_out.hs_n;
    assign VGAvs      = ctl_out.vs_n;
    assign VGAblankN  = ctl_out.blank_n;
    assign frameStart = ctl_out.frame_start;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have port clk, input, 1, single clock for all state; the block has one clock domain.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port pixEn, input, 1, pixel-rate enable; the timing advances only on cycles where it is 1.
REQ-008 SHALL have ports xPixel, output, 10, and yPixel, output, 9, the current visible coordinate driven to the drawing controller.
REQ-009 SHALL have ports inR/inG/inB, input, 8 each, combinational colour returned by the drawing controller for the current xPixel/yPixel.
REQ-010 SHALL have ports VGAr/VGAg/VGAb, output, 8 each, registered colour to the DAC.
REQ-011 SHALL have ports VGAhs and VGAvs, output, 1 each, active-low syncs.
REQ-012 SHALL have port VGAblankN, output, 1, low outside the visible area.
REQ-013 SHALL have port frameStart, output, 1, one-pixEn pulse aligned to the first visible pixel of a frame on VGAr.

Function
REQ-014 SHALL keep internal counters hCnt 0..H_TOTAL-1 and vCnt 0..V_TOTAL-1, where H_TOTAL=800 and V_TOTAL=525 at defaults.
REQ-015 On pixEn=1, hCnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vCnt SHALL increment; vCnt SHALL wrap to 0 from V_TOTAL-1 on that same cycle.
REQ-016 With pixEn=0, all counters and output registers SHALL hold their values.
REQ-017 The visible area SHALL be defined as active = (hCnt<H_ACTIVE && vCnt<V_ACTIVE).
REQ-018 xPixel/yPixel SHALL be registered and equal hCnt/vCnt when active, and 0 otherwise.
REQ-019 Raw hsync SHALL be low for hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is 656..751 at defaults.
REQ-020 Raw vsync SHALL be low for vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], which is 490..491 at defaults.
REQ-021 On each pixEn cycle, inR/G/B SHALL be sampled into VGAr/g/b, giving a latency of 1 pixEn cycle from xPixel/yPixel to colour.
REQ-022 VGAhs, VGAvs, VGAblankN and frameStart SHALL be delayed by the same stage count as the colour path so that all DAC outputs are mutually aligned.
REQ-023 When the pixel being output is not active, VGAr/g/b SHALL be forced to 0 regardless of inR/G/B.
REQ-024 Sync generation SHALL use comparisons on full-width counters; there SHALL be no 9-bit truncation of vCnt before the active test.

Reset
REQ-025 While rst_n=0, the block SHALL set hCnt=0, vCnt=0, xPixel=0, yPixel=0, VGAr/g/b=0, VGAhs=1, VGAvs=1, VGAblankN=0 and frameStart=0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately.
REQ-027 After reset release, the first pixEn cycle SHALL present pixel (0,0) and restart the frame.

Configuration
REQ-028 With macro VGA_EXTRA_PIPE_EN defined, one additional register stage SHALL be inserted on colour, syncs, blank and frameStart, making the latency 2 pixEn cycles.
REQ-029 Without VGA_EXTRA_PIPE_EN, the latency SHALL be exactly 1 pixEn cycle.
REQ-030 Counter behaviour SHALL be identical with and without VGA_EXTRA_PIPE_EN.

Structure
REQ-031 Default timing constants, H_TOTAL/V_TOTAL derivation and the RGB colour struct SHALL reside in the shared package vga_timing_pkg.
REQ-032 Each axis counter (count, wrap, carry-out) SHALL be one sub-module, vga_axis_counter, instantiated twice: horizontal, with carry driving the vertical enable; and vertical.

Verification
REQ-033 The bench SHALL check: reset, then pixEn=1 constantly -> xPixel runs 0..639 and is 0 for hCnt 640..799; VGAhs is low for exactly 96 cycles starting 656 cycles after line start (+latency).
REQ-034 The bench SHALL check: run 800*525 pixEn cycles -> vCnt wraps 524->0, VGAvs is low for 2 lines (1600 cycles), and frameStart pulses exactly once per 420000 cycles.
REQ-035 The bench SHALL check: inR=xPixel[7:0] fed back combinationally -> VGAr at cycle N+1 equals xPixel[7:0] of cycle N, and VGAr=0 whenever VGAblankN=0.
REQ-036 The bench SHALL check: pixEn toggling 1,0,1,0 -> counters advance only on pixEn=1 cycles, and outputs are stable across pixEn=0 cycles.
REQ-037 The bench SHALL check: rst_n pulsed low at hCnt=300, vCnt=200 -> outputs take their reset values asynchronously, and the next pixEn after release yields xPixel=0, yPixel=0.
REQ-038 The bench SHALL check: with VGA_EXTRA_PIPE_EN defined, rerun the REQ-035 scenario -> VGAr at N+2 equals xPixel[7:0] of cycle N, and the syncs are shifted by the same one extra cycle.
